// File: rtl/keypad_matrix_responder.sv
// Emulates a 4x3 keypad matrix: holds a host-requested key for a number of scan cycles.
// Optional contact bounce on hold/release entry is enabled with `define KEYPAD_BOUNCE_EN.
module keypad_matrix_responder #(
   parameter int unsigned HOLD_W        = 8,
   parameter int unsigned RELEASE_SCANS = 2,
   parameter int unsigned BOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        row,
   output logic [2:0]        column,
   input  logic              req_valid,
   input  logic [3:0]        req_key,
   input  logic [HOLD_W-1:0] req_hold,
   output logic              req_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, PRESS, HOLD, RELEASE} state_t;

   localparam logic [HOLD_W:0] REL_N = (HOLD_W+1)'(RELEASE_SCANS);

   state_t            state, state_nx;
   logic [3:0]        row_q;
   logic [1:0]        key_row, key_row_nx;
   logic [1:0]        key_col, key_col_nx;
   logic [HOLD_W-1:0] hold_len, hold_len_nx;
   logic [HOLD_W-1:0] scan_cnt, scan_cnt_nx;
   logic [HOLD_W:0]   scan_inc;
   logic [2:0]        column_nx;
   logic              done_nx, err_nx;
   logic              tick, key_active;

`ifdef KEYPAD_BOUNCE_EN
   localparam int unsigned BCW = (BOUNCE_CYCLES < 1) ? 1 : $clog2(BOUNCE_CYCLES + 1);
   logic [BCW-1:0] bounce_cnt, bounce_cnt_nx;
   logic           bounce_phase, bounce_phase_nx;
`endif

   assign tick      = (row == 4'b0001) && (row_q != 4'b0001);
   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx    = state;
      key_row_nx  = key_row;
      key_col_nx  = key_col;
      hold_len_nx = hold_len;
      scan_cnt_nx = scan_cnt;
      done_nx     = 1'b0;
      err_nx      = 1'b0;
      // one extra bit so a hold of 2^HOLD_W-1 compares before wrapping
      scan_inc    = {1'b0, scan_cnt} + (HOLD_W+1)'(1);
      key_active  = (state == PRESS) || (state == HOLD);

      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_key >= 4'd12) begin
                  err_nx = 1'b1;
               end else begin
                  state_nx    = PRESS;
                  key_row_nx  = 2'(req_key / 4'd3);
                  key_col_nx  = 2'(req_key % 4'd3);
                  hold_len_nx = (req_hold == '0) ? HOLD_W'(1) : req_hold;
               end
            end
         end
         PRESS: begin
            state_nx    = HOLD;
            scan_cnt_nx = '0;
         end
         HOLD: begin
            if (tick) begin
               if (scan_inc == {1'b0, hold_len}) begin
                  state_nx    = RELEASE;
                  scan_cnt_nx = '0;
               end else begin
                  scan_cnt_nx = scan_inc[HOLD_W-1:0];
               end
            end
         end
         RELEASE: begin
            if (tick) begin
               if (scan_inc == REL_N) begin
                  state_nx    = IDLE;
                  scan_cnt_nx = '0;
                  done_nx     = 1'b1;
               end else begin
                  scan_cnt_nx = scan_inc[HOLD_W-1:0];
               end
            end
         end
         default: state_nx = IDLE;
      endcase

`ifdef KEYPAD_BOUNCE_EN
      bounce_cnt_nx   = (bounce_cnt != '0) ? bounce_cnt - BCW'(1) : '0;
      bounce_phase_nx = ~bounce_phase;
      if ((state_nx != state) && ((state_nx == HOLD) || (state_nx == RELEASE))) begin
         bounce_cnt_nx   = BCW'(BOUNCE_CYCLES);
         bounce_phase_nx = (state_nx == HOLD);
      end else if ((state_nx == IDLE) || (state_nx == PRESS)) begin
         bounce_cnt_nx = '0;
      end
      if ((bounce_cnt != '0) && ((state == HOLD) || (state == RELEASE)))
         key_active = bounce_phase;
`endif

      column_nx = (key_active && row[key_row]) ? (3'b001 << key_col) : 3'b000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         row_q    <= '0;
         key_row  <= '0;
         key_col  <= '0;
         hold_len <= '0;
         scan_cnt <= '0;
         column   <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
         bounce_cnt   <= '0;
         bounce_phase <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         row_q    <= row;
         key_row  <= key_row_nx;
         key_col  <= key_col_nx;
         hold_len <= hold_len_nx;
         scan_cnt <= scan_cnt_nx;
         column   <= column_nx;
         done     <= done_nx;
         err      <= err_nx;
`ifdef KEYPAD_BOUNCE_EN
         bounce_cnt   <= bounce_cnt_nx;
         bounce_phase <= bounce_phase_nx;
`endif
      end
   end

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Randomized bench for keypad_matrix_responder against a countdown-based key-hold model.
// Directed runs: basic press, illegal key, zero hold, backpressure, max hold, reset mid-hold.
module tb_keypad_matrix_responder;

   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned REL     = 2;
   localparam int unsigned BOUNCE  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        row;
   logic [2:0]        column;
   logic              req_valid;
   logic [3:0]        req_key;
   logic [HOLD_W-1:0] req_hold;
   logic              req_ready, busy, done, err;

   keypad_matrix_responder #(
      .HOLD_W(HOLD_W), .RELEASE_SCANS(REL), .BOUNCE_CYCLES(BOUNCE)
   ) dut (
      .clk(clk), .rst(rst), .row(row), .column(column),
      .req_valid(req_valid), .req_key(req_key), .req_hold(req_hold),
      .req_ready(req_ready), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference model: key currently held (-1 = none) plus remaining scan countdowns.
   int   mkey, mhold, holds_left, rels_left, bleft;
   bit   pressing, bph, took;
   logic [3:0] mprev;
   logic [2:0] e_col;
   logic e_done, e_err;

   task automatic model_reset();
      mkey = -1; mhold = 0; holds_left = 0; rels_left = 0; bleft = 0;
      pressing = 0; bph = 0; took = 0; mprev = 4'b0000;
      e_col = 3'b000; e_done = 0; e_err = 0;
   endtask

   task automatic model_step();
      bit tk, d;
      tk = (row == 4'b0001) && (mprev != 4'b0001);
      mprev = row;
      d = pressing || (holds_left > 0);
      if (bleft > 0 && (holds_left > 0 || rels_left > 0)) d = bph;
      e_col = (d && mkey >= 0 && row[mkey/3]) ? 3'(1 << (mkey % 3)) : 3'b000;
      e_err = 0; e_done = 0; took = 0;
      if (bleft > 0) begin bleft--; bph = !bph; end
      if (mkey < 0) begin
         if (req_valid) begin
            took = 1;
            if (req_key >= 12) e_err = 1;
            else begin
               mkey = int'(req_key); pressing = 1;
               mhold = (req_hold == 0) ? 1 : int'(req_hold);
            end
         end
      end else if (pressing) begin
         pressing = 0; holds_left = mhold;
`ifdef KEYPAD_BOUNCE_EN
         bleft = BOUNCE; bph = 1;
`endif
      end else if (holds_left > 0) begin
         if (tk) begin
            holds_left--;
            if (holds_left == 0) begin
               rels_left = REL;
`ifdef KEYPAD_BOUNCE_EN
               bleft = BOUNCE; bph = 0;
`endif
            end
         end
      end else if (tk) begin
         rels_left--;
         if (rels_left == 0) begin mkey = -1; e_done = 1; bleft = 0; end
      end
   endtask

   // Scanner and host stimulus state
   int  per = 8, timer = 0, ridx = 0;
   bit  junk = 0, rand_host = 0;

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_eq("column", column, e_col);
      check_eq("done", done, e_done);
      check_eq("err", err, e_err);
      check_eq("req_ready", req_ready, mkey < 0);
      check_eq("busy", busy, mkey >= 0);
      if (junk) row = 4'($urandom);
      else begin
         timer++;
         if (timer >= per) begin timer = 0; ridx = (ridx + 1) % 4; row = 4'(1 << ridx); end
      end
      if (took) req_valid = 0;
      if (rand_host && !req_valid && $urandom_range(0, 3) == 0) begin
         req_valid = 1;
         req_key   = 4'($urandom_range(0, 15));
         req_hold  = HOLD_W'($urandom_range(0, 3));
      end
   endtask

   task automatic issue(input int key, input int hold);
      req_valid = 1; req_key = 4'(key); req_hold = HOLD_W'(hold);
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n = 0;
      while (!(mkey < 0 && !req_valid) && n < budget) begin cycle(); n++; end
      check_eq(tag, n < budget, 1'b1);
   endtask

   int dones, errs, hits;

   initial begin
      rst = 1; row = 4'b0000; req_valid = 0; req_key = 0; req_hold = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_column", column, 3'b000);
      check_eq("rst_ready", req_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_err", err, 1'b0);
      @(negedge clk); rst = 0;
      row = 4'b0001; ridx = 0; timer = 0; per = 8;
      repeat (5) cycle();

      // basic press: key 4 (row1,col1), hold 3
      issue(4, 3);
      dones = 0; hits = 0;
      for (int i = 0; i < 400 && !(mkey < 0 && !req_valid); i++) begin
         cycle();
         if (done) dones++;
         if (column == 3'b010) hits++;
      end
      check_eq("basic_done_once", dones, 1);
      check_eq("basic_column_clks", hits, 3 * per);

      // illegal key
      issue(12, 2);
      errs = 0;
      for (int i = 0; i < 40; i++) begin cycle(); if (err) errs++; end
      check_eq("illegal_err_once", errs, 1);

      // zero hold: key 11 behaves as hold 1
      issue(11, 0);
      hits = 0;
      for (int i = 0; i < 300 && !(mkey < 0 && !req_valid); i++) begin
         cycle(); if (column == 3'b100) hits++;
      end
      check_eq("zero_hold_column_clks", hits, per);

      // busy backpressure: key 5 then key 0 queued while busy
      issue(5, 1);
      while (!took) cycle();
      issue(0, 1);
      for (int i = 0; i < 300 && !done; i++) cycle();
      check_eq("bp_ready_at_done", req_ready, 1'b1);
      cycle();
      check_eq("bp_second_accepted", busy, 1'b1);
      run_until_idle("bp_idle", 400);

      // maximum hold with fast scanning
      per = 1;
      issue(7, (1 << HOLD_W) - 1);
      run_until_idle("max_hold_idle", 1200);

      // reset mid-hold with key 0 driving column 001
      per = 2;
      issue(0, 20);
      hits = 0;
      for (int i = 0; i < 200 && !(holds_left > 0 && column == 3'b001); i++) cycle();
      check_eq("mid_hold_reached", column, 3'b001);
      #2 rst = 1;
      #1;
      check_eq("async_rst_column", column, 3'b000);
      check_eq("async_rst_ready", req_ready, 1'b1);
      check_eq("async_rst_busy", busy, 1'b0);
      model_reset();
      req_valid = 0;
      @(posedge clk); #1;
      check_eq("rst_hold_done", done, 1'b0);
      @(negedge clk); rst = 0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin cycle(); if (done) dones++; end
      check_eq("no_done_after_rst", dones, 0);

      // randomized traffic with varying scan rates and glitchy rows
      rand_host = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) begin
            per  = $urandom_range(1, 8);
            junk = ($urandom_range(0, 9) == 0);
         end
         cycle();
      end
      rand_host = 0; junk = 0;
      run_until_idle("random_drain", 800);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
